// File: rtl/h80cpu_bus_arbiter_if.sv
// Toggle-handshake bus port used between the h80cpu bus masters, the arbiter and the word memory.
// Handshake: the master sets addr/cmd/wr_data and then flips run; a request is pending while
// run != done. The target flips done back to equal run when finished, and rd_data is valid from then on.
interface h80cpu_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CMD_W  = 3
);
    logic [ADDR_W-1:0] addr;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] wr_data;
    logic              run;
    logic [DATA_W-1:0] rd_data;
    logic              done;

    modport master (output addr, cmd, wr_data, run, input rd_data, done);
    modport slave  (input addr, cmd, wr_data, run, output rd_data, done);
endinterface

// File: rtl/h80cpu_bus_arbiter.sv
// Two-master round-robin arbiter that shares one toggle-handshake target between the h80cpu core
// (m0) and a second master (m1), forwarding one transaction at a time.
module h80cpu_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CMD_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    h80cpu_bus_arbiter_if.slave   m0,
    h80cpu_bus_arbiter_if.slave   m1,
    h80cpu_bus_arbiter_if.master  t,
    output logic                  grant,
    output logic                  busy,
    output logic                  state_dbg
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              last;
    logic              grant_q;
    logic              pend0;
    logic              pend1;
    logic              sel;
    logic              start;
    logic              complete;
    logic [ADDR_W-1:0] t_addr_q;
    logic [CMD_W-1:0]  t_cmd_q;
    logic [DATA_W-1:0] t_wr_data_q;
    logic              t_run_q;
    logic [DATA_W-1:0] m0_rd_data_q;
    logic [DATA_W-1:0] m1_rd_data_q;
    logic              m0_done_q;
    logic              m1_done_q;

    assign pend0 = m0.run ^ m0_done_q;
    assign pend1 = m1.run ^ m1_done_q;
    // On a tie the master that was not served last wins; otherwise the only pending one.
    assign sel   = (pend0 && pend1) ? ~last : pend1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pend0 || pend1) state_nxt = S_WAIT;
            S_WAIT:  if (t.done == t_run_q) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        complete = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE: start = pend0 || pend1;
            S_WAIT: begin
                busy     = 1'b1;
                complete = (t.done == t_run_q);
            end
            default: begin
                start    = 1'b0;
                complete = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Master inputs are captured only at selection, so they may change freely during WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last         <= 1'b1;
            grant_q      <= 1'b0;
            t_addr_q     <= '0;
            t_cmd_q      <= '0;
            t_wr_data_q  <= '0;
            t_run_q      <= 1'b0;
            m0_rd_data_q <= '0;
            m1_rd_data_q <= '0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
        end else begin
            if (start) begin
                grant_q <= sel;
                t_run_q <= ~t_run_q;
                if (sel) begin
                    t_addr_q    <= m1.addr;
                    t_cmd_q     <= m1.cmd;
                    t_wr_data_q <= m1.wr_data;
                end else begin
                    t_addr_q    <= m0.addr;
                    t_cmd_q     <= m0.cmd;
                    t_wr_data_q <= m0.wr_data;
                end
            end
            if (complete) begin
                last <= grant_q;
                if (grant_q) begin
                    m1_rd_data_q <= t.rd_data;
                    m1_done_q    <= ~m1_done_q;
                end else begin
                    m0_rd_data_q <= t.rd_data;
                    m0_done_q    <= ~m0_done_q;
                end
            end
        end
    end

    assign t.addr     = t_addr_q;
    assign t.cmd      = t_cmd_q;
    assign t.wr_data  = t_wr_data_q;
    assign t.run      = t_run_q;
    assign m0.rd_data = m0_rd_data_q;
    assign m0.done    = m0_done_q;
    assign m1.rd_data = m1_rd_data_q;
    assign m1.done    = m1_done_q;
    assign grant      = grant_q;
    assign state_dbg  = (state == S_WAIT);
endmodule

// File: tb/tb_h80cpu_bus_arbiter.sv
// Bench for h80cpu_bus_arbiter: word-memory target model, two master drivers, a byte-level
// reference memory feeding per-master expected queues, and a negedge monitor that checks completions.
module tb_h80cpu_bus_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CMD_W  = 3;
    localparam logic [CMD_W-1:0] CMD_RD_W = 3'd0;
    localparam logic [CMD_W-1:0] CMD_RD_B = 3'd1;
    localparam logic [CMD_W-1:0] CMD_WR_W = 3'd2;
    localparam logic [CMD_W-1:0] CMD_WR_B = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic grant;
    logic busy;
    logic state_dbg;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    h80cpu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W)) m0_bus ();
    h80cpu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W)) m1_bus ();
    h80cpu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W)) t_bus ();

    h80cpu_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W)) dut (
        .clk(clk),
        .reset(reset),
        .m0(m0_bus),
        .m1(m1_bus),
        .t(t_bus),
        .grant(grant),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- target: word memory, done after t_delay edges ----------------
    logic [15:0] mem [0:32767];
    int t_delay = 1;
    int t_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_bus.done    <= 1'b0;
            t_bus.rd_data <= '0;
            t_cnt         <= 0;
        end else if (t_bus.run != t_bus.done) begin
            if (t_cnt + 1 >= t_delay) begin
                t_cnt      <= 0;
                t_bus.done <= ~t_bus.done;
                case (t_bus.cmd)
                    CMD_RD_W: t_bus.rd_data <= mem[t_bus.addr[15:1]];
                    CMD_RD_B: t_bus.rd_data <= t_bus.addr[0] ? {8'h00, mem[t_bus.addr[15:1]][15:8]}
                                                             : {8'h00, mem[t_bus.addr[15:1]][7:0]};
                    CMD_WR_W: begin
                        mem[t_bus.addr[15:1]] <= t_bus.wr_data;
                        t_bus.rd_data         <= ~t_bus.wr_data;
                    end
                    CMD_WR_B: begin
                        if (t_bus.addr[0]) mem[t_bus.addr[15:1]][15:8] <= t_bus.wr_data[7:0];
                        else               mem[t_bus.addr[15:1]][7:0]  <= t_bus.wr_data[7:0];
                        t_bus.rd_data <= ~t_bus.wr_data;
                    end
                    default: t_bus.rd_data <= 16'h0000;
                endcase
            end else begin
                t_cnt <= t_cnt + 1;
            end
        end
    end

    // ---------------- reference model: byte-addressed little-endian memory ----------------
    logic [7:0] ref_bytes [int];

    // Returns {is_read, expected rd_data}; writes update the model and return is_read = 0.
    function automatic logic [16:0] ref_access(input logic [2:0] cmd, input logic [15:0] addr,
                                               input logic [15:0] wd);
        int lo;
        lo = int'({addr[15:1], 1'b0});
        case (cmd)
            CMD_RD_W: return {1'b1, ref_bytes[lo + 1], ref_bytes[lo]};
            CMD_RD_B: return {1'b1, 8'h00, ref_bytes[int'(addr)]};
            CMD_WR_W: begin
                ref_bytes[lo]     = wd[7:0];
                ref_bytes[lo + 1] = wd[15:8];
            end
            CMD_WR_B: ref_bytes[int'(addr)] = wd[7:0];
            default: ;
        endcase
        return 17'h0;
    endfunction

    // ---------------- scoreboard queues ----------------
    logic [16:0] exp_q0[$];
    logic [16:0] exp_q1[$];
    int req_cyc [2] = '{0, 0};

    function automatic logic pending(input int m);
        return (m == 0) ? (m0_bus.run ^ m0_bus.done) : (m1_bus.run ^ m1_bus.done);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input int m, input logic [2:0] cmd, input logic [15:0] addr,
                         input logic [15:0] wd);
        int n;
        logic [16:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pending(m) && n < 300);
        if (pending(m)) begin
            total++;
            bad++;
            $display("FAIL issue_timeout m%0d: still pending after %0d cycles, want idle", m, n);
        end else begin
            e = ref_access(cmd, addr, wd);
            req_cyc[m] = cyc;
            if (m == 0) begin
                exp_q0.push_back(e);
                m0_bus.addr    = addr;
                m0_bus.cmd     = cmd;
                m0_bus.wr_data = wd;
                m0_bus.run     = ~m0_bus.run;
            end else begin
                exp_q1.push_back(e);
                m1_bus.addr    = addr;
                m1_bus.cmd     = cmd;
                m1_bus.wr_data = wd;
                m1_bus.run     = ~m1_bus.run;
            end
        end
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((pending(0) || pending(1) || busy) && n < 500);
        check("quiet_timeout", {31'b0, pending(0) || pending(1) || busy}, 0);
        @(negedge clk);
    endtask

    task automatic rand_master(input int m, input logic [15:0] base);
        logic [15:0] a;
        logic [2:0]  c;
        for (int i = 0; i < 8; i++) issue(m, CMD_WR_W, base + 16'(2 * i), 16'($urandom));
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            c = 3'($urandom_range(0, 3));
            a = base + 16'($urandom_range(0, 15));
            issue(m, c, a, 16'($urandom));
        end
    endtask

    // ---------------- monitor ----------------
    logic        p_done0, p_done1, p_trun, p_tdone;
    logic [16:0] mon_e;
    logic [15:0] snap_addr, snap_wd;
    logic [2:0]  snap_cmd;
    int          done_cnt [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    logic [15:0] last_rd [2];
    int          start_grant_q[$];
    int          start_cyc_q[$];
    int          busy_len_q[$];
    int          busy_len;
    int          stab_err = 0;

    always @(negedge clk) begin
        if (reset) begin
            p_done0  = m0_bus.done;
            p_done1  = m1_bus.done;
            p_trun   = t_bus.run;
            p_tdone  = t_bus.done;
            busy_len = 0;
        end else begin
            if (m0_bus.done != p_done0) begin
                done_cnt[0]++;
                done_cyc[0] = cyc;
                last_rd[0]  = m0_bus.rd_data;
                check("m0_done_expected", {31'b0, exp_q0.size() != 0}, 1);
                check("m0_done_grant", {31'b0, grant}, 0);
                if (exp_q0.size() != 0) begin
                    mon_e = exp_q0.pop_front();
                    if (mon_e[16]) check("m0_rd_data", {16'b0, m0_bus.rd_data}, {16'b0, mon_e[15:0]});
                end
            end
            if (m1_bus.done != p_done1) begin
                done_cnt[1]++;
                done_cyc[1] = cyc;
                last_rd[1]  = m1_bus.rd_data;
                check("m1_done_expected", {31'b0, exp_q1.size() != 0}, 1);
                check("m1_done_grant", {31'b0, grant}, 1);
                if (exp_q1.size() != 0) begin
                    mon_e = exp_q1.pop_front();
                    if (mon_e[16]) check("m1_rd_data", {16'b0, m1_bus.rd_data}, {16'b0, mon_e[15:0]});
                end
            end
            if (t_bus.run != p_trun) begin
                check("t_run_only_when_idle", {31'b0, p_trun}, {31'b0, p_tdone});
                start_grant_q.push_back(int'(grant));
                start_cyc_q.push_back(cyc);
                snap_addr = t_bus.addr;
                snap_cmd  = t_bus.cmd;
                snap_wd   = t_bus.wr_data;
            end else if (busy) begin
                if (t_bus.addr !== snap_addr || t_bus.cmd !== snap_cmd || t_bus.wr_data !== snap_wd)
                    stab_err++;
            end
            if (busy) busy_len++;
            else if (busy_len != 0) begin
                busy_len_q.push_back(busy_len);
                busy_len = 0;
            end
            p_done0 = m0_bus.done;
            p_done1 = m1_bus.done;
            p_trun  = t_bus.run;
            p_tdone = t_bus.done;
        end
    end

    // ---------------- stimulus sequence ----------------
    int n0, b0, d0, d1, s0;

    initial begin
        reset = 1'b0;
        m0_bus.run = 1'b0; m0_bus.addr = '0; m0_bus.cmd = '0; m0_bus.wr_data = '0;
        m1_bus.run = 1'b0; m1_bus.addr = '0; m1_bus.cmd = '0; m1_bus.wr_data = '0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", {31'b0, grant}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_state", {31'b0, state_dbg}, 0);
        check("rst_t_run", {31'b0, t_bus.run}, 0);
        check("rst_t_addr", {16'b0, t_bus.addr}, 0);
        check("rst_m_done", {30'b0, m1_bus.done, m0_bus.done}, 0);
        reset = 1'b0;

        // single read by master 0
        t_delay = 1;
        issue(0, CMD_WR_W, 16'h2020, 16'h6548);
        wait_quiet();
        d1 = done_cnt[1];
        n0 = start_cyc_q.size();
        issue(0, CMD_RD_W, 16'h2020, 16'h0000);
        wait_quiet();
        check("rd_start_latency", start_cyc_q[n0] - req_cyc[0], 1);
        check("rd_done_latency", done_cyc[0] - start_cyc_q[n0], 2);
        check("rd_m0_data", {16'b0, last_rd[0]}, 32'h6548);
        check("rd_m1_done_quiet", done_cnt[1], d1);

        // byte write then word read by master 1
        n0 = start_grant_q.size();
        issue(1, CMD_WR_W, 16'h2000, 16'h1234);
        issue(1, CMD_WR_B, 16'h2001, 16'h00AB);
        issue(1, CMD_RD_W, 16'h2000, 16'h0000);
        wait_quiet();
        for (int i = 0; i < 3; i++) check("byte_grant", start_grant_q[n0 + i], 1);
        check("byte_result", {16'b0, last_rd[1]}, 32'hAB34);
        check("byte_grant_idle", {31'b0, grant}, 1);

        // simultaneous requests, four rounds each
        n0 = start_grant_q.size();
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        fork
            begin for (int i = 0; i < 4; i++) issue(0, CMD_RD_W, 16'h2020, 16'h0000); end
            begin for (int i = 0; i < 4; i++) issue(1, CMD_RD_W, 16'h2000, 16'h0000); end
        join
        wait_quiet();
        for (int i = 0; i < 8; i++) check("rr_order", start_grant_q[n0 + i], i % 2);
        for (int i = 1; i < 8; i++) check("rr_spacing", start_cyc_q[n0 + i] - start_cyc_q[n0 + i - 1], 3);
        check("rr_m0_dones", done_cnt[0] - d0, 4);
        check("rr_m1_dones", done_cnt[1] - d1, 4);

        // slow target with a master-1 request arriving mid-wait
        t_delay = 5;
        n0 = start_cyc_q.size();
        b0 = busy_len_q.size();
        s0 = stab_err;
        fork
            issue(0, CMD_RD_W, 16'h2020, 16'h0000);
            begin repeat (3) @(negedge clk); issue(1, CMD_RD_W, 16'h2000, 16'h0000); end
        join
        wait_quiet();
        check("slow_busy_len0", busy_len_q[b0], 6);
        check("slow_busy_len1", busy_len_q[b0 + 1], 6);
        check("slow_order0", start_grant_q[n0], 0);
        check("slow_order1", start_grant_q[n0 + 1], 1);
        check("slow_next_start", start_cyc_q[n0 + 1] - start_cyc_q[n0], 7);
        check("slow_t_stable", stab_err - s0, 0);

        // master input changes during WAIT are ignored
        t_delay = 3;
        issue(0, CMD_WR_W, 16'h0000, 16'h0F0F);
        issue(0, CMD_WR_W, 16'hFFFE, 16'hF0F0);
        wait_quiet();
        issue(0, CMD_RD_W, 16'h0000, 16'h0000);
        @(negedge clk);
        m0_bus.addr = 16'hFFFE;
        @(negedge clk);
        check("hold_busy", {31'b0, busy}, 1);
        check("hold_t_addr", {16'b0, t_bus.addr}, 0);
        wait_quiet();
        check("hold_rd_data", {16'b0, last_rd[0]}, 32'h0F0F);

        // asynchronous reset mid-WAIT, after m0 was served last
        t_delay = 1;
        issue(1, CMD_RD_W, 16'h2000, 16'h0000);
        wait_quiet();
        issue(0, CMD_RD_W, 16'h2020, 16'h0000);
        wait_quiet();
        t_delay = 5;
        issue(1, CMD_RD_W, 16'h2000, 16'h0000);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_t_run", {31'b0, t_bus.run}, 0);
        check("arst_t_addr", {16'b0, t_bus.addr}, 0);
        check("arst_t_cmd_wd", {13'b0, t_bus.cmd, t_bus.wr_data}, 0);
        check("arst_m0_rd", {16'b0, m0_bus.rd_data}, 0);
        check("arst_m1_rd", {16'b0, m1_bus.rd_data}, 0);
        check("arst_done", {30'b0, m1_bus.done, m0_bus.done}, 0);
        check("arst_grant", {31'b0, grant}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        exp_q0.delete();
        exp_q1.delete();
        m0_bus.run = 1'b0;
        m1_bus.run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t_delay = 1;
        n0 = start_grant_q.size();
        fork
            issue(0, CMD_RD_W, 16'h2020, 16'h0000);
            issue(1, CMD_RD_W, 16'h2000, 16'h0000);
        join
        wait_quiet();
        check("arst_tie_first", start_grant_q[n0], 0);
        check("arst_tie_second", start_grant_q[n0 + 1], 1);

        // randomized traffic on disjoint regions
        for (int r = 0; r < 2; r++) begin
            t_delay = $urandom_range(1, 4);
            fork
                rand_master(0, 16'h0200);
                rand_master(1, 16'h0400);
            join
            wait_quiet();
        end

        check("m0_queue_drained", exp_q0.size(), 0);
        check("m1_queue_drained", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
